// File: rtl/segment_tracker.sv
// Segment header/payload tracker: decodes 32-bit headers from a word stream and forwards
// payload words with a byte mask, an end-of-segment flag and start/done pulses.
module segment_tracker #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   din,
    input  logic                din_valid,
    output logic                din_ready,
    output logic [DATA_W-1:0]   dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic [DATA_W/8-1:0] dout_bmask,
    output logic                dout_seg_end,
    output logic                seg_start,
    output logic                seg_done,
    output logic [3:0]          htype,
    output logic [3:0]          sel_nibble,
    output logic                flag_last,
    output logic                flag_eoi,
    output logic                flag_eot,
    output logic [LEN_W-1:0]    seg_len,
    output logic                hdr_error,
    input  logic                err_clear
);

    localparam int BPW = DATA_W / 8;
    localparam logic [LEN_W-1:0] BPW_LEN = LEN_W'(BPW);

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_DATA = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [LEN_W-1:0] rem;
    logic [LEN_W-1:0] hdr_len;
    logic             hdr_ok;
    logic             last_word;
    logic [BPW-1:0]   tail_mask;
    logic             ready_raw;
    logic             hdr_take;
    logic             bad_take;
    logic             data_take;
    logic             err_ack;

    assign hdr_ok    = din[16] && (din[19:17] == 3'b000);
    assign hdr_len   = LEN_W'(din[15:0]);
    assign last_word = (rem <= BPW_LEN);
    // A short final word keeps its leading bytes, which live at the top of the word.
    assign tail_mask = ~({BPW{1'b1}} >> rem);
    assign din_ready = rst_n & ready_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_HDR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready_raw  = 1'b0;
        hdr_take   = 1'b0;
        bad_take   = 1'b0;
        data_take  = 1'b0;
        err_ack    = 1'b0;
        case (state)
            S_HDR: begin
                ready_raw = 1'b1;
                if (din_valid) begin
                    if (hdr_ok) begin
                        hdr_take = 1'b1;
                        if (hdr_len != '0) begin
                            state_next = S_DATA;
                        end
                    end else begin
                        bad_take   = 1'b1;
                        state_next = S_ERR;
                    end
                end
            end
            S_DATA: begin
                ready_raw = !dout_valid || dout_ready;
                if (din_valid && ready_raw) begin
                    data_take = 1'b1;
                    if (last_word) begin
                        state_next = S_HDR;
                    end
                end
            end
            S_ERR: begin
                if (err_clear) begin
                    err_ack    = 1'b1;
                    state_next = S_HDR;
                end
            end
            default: begin
                state_next = S_HDR;
            end
        endcase
    end

    // Header fields stay latched until the next valid header; a bad header leaves them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            htype      <= 4'h0;
            sel_nibble <= 4'h0;
            flag_last  <= 1'b0;
            flag_eoi   <= 1'b0;
            flag_eot   <= 1'b0;
            seg_len    <= '0;
            hdr_error  <= 1'b0;
        end else begin
            if (hdr_take) begin
                htype      <= din[31:28];
                sel_nibble <= din[23:20];
                flag_last  <= din[24];
                flag_eoi   <= din[25];
                flag_eot   <= din[26];
                seg_len    <= hdr_len;
            end
            if (bad_take) begin
                hdr_error <= 1'b1;
            end else if (err_ack) begin
                hdr_error <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem <= '0;
        end else if (hdr_take) begin
            rem <= hdr_len;
        end else if (data_take) begin
            rem <= last_word ? '0 : (rem - BPW_LEN);
        end
    end

    // One-entry output register; it keeps draining even while the FSM waits on headers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout         <= '0;
            dout_valid   <= 1'b0;
            dout_bmask   <= '0;
            dout_seg_end <= 1'b0;
        end else if (data_take) begin
            dout         <= din;
            dout_valid   <= 1'b1;
            dout_bmask   <= (rem >= BPW_LEN) ? {BPW{1'b1}} : tail_mask;
            dout_seg_end <= last_word;
        end else if (dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_start <= 1'b0;
            seg_done  <= 1'b0;
        end else begin
            seg_start <= hdr_take;
            seg_done  <= (hdr_take && (hdr_len == '0)) || (data_take && last_word);
        end
    end

endmodule
